cpu_memory_system: RTL and testbench

Responder side of the CPU memory interface. Serves the core's two read ports (instruction fetch on port 0, data load on port 1) and its byte-enabled write port from a shared word RAM with one-cycle registered read latency. Also decodes two memory-mapped registers: a console transmit FIFO with a valid/ready drain interface, and a free-running cycle timer. Sits directly opposite the pipelined core at top level; the core's fetch and writeback stages consume read data exactly one cycle after presenting the address.

---
 rtl/cpu_memory_system_if.sv | 40 ++++
 rtl/cpu_memory_system.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_memory_system.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_memory_system_if.sv
// Bus between the pipelined core (master) and the memory responder (slave):
// two read ports, one byte-enabled write port and the console drain channel.
interface cpu_memory_system_if;
    logic [31:0] mem_read0_addr;
    logic [31:0] mem_read0_data;
    logic [31:0] mem_read1_addr;
    logic [31:0] mem_read1_data;
    logic [3:0]  mem_we;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    modport master (
        output mem_read0_addr,
        input  mem_read0_data,
        output mem_read1_addr,
        input  mem_read1_data,
        output mem_we,
        output mem_write_addr,
        output mem_write_data,
        input  con_valid,
        input  con_data,
        output con_ready
    );

    modport slave (
        input  mem_read0_addr,
        output mem_read0_data,
        input  mem_read1_addr,
        output mem_read1_data,
        input  mem_we,
        input  mem_write_addr,
        input  mem_write_data,
        output con_valid,
        output con_data,
        input  con_ready
    );
endinterface

// File: rtl/cpu_memory_system.sv
// Shared word RAM with two registered read ports and a byte-lane write port,
// plus a console transmit FIFO and a free-running cycle timer at fixed MMIO addresses.
module cpu_memory_system #(
    parameter int          ADDR_BITS    = 14,
    parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF_FFF0,
    parameter logic [31:0] TIMER_ADDR   = 32'hFFFF_FFF4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    cpu_memory_system_if.slave  bus
);
    localparam int WORDS = 2 ** ADDR_BITS;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [7:0]       DEPTH_CNT = 8'(FIFO_DEPTH);

    function automatic logic is_mmio(input logic [31:0] addr);
        return (addr == CONSOLE_ADDR) || (addr == TIMER_ADDR);
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  we);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = we[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1'b1);
        end
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [31:0]      ram_r [WORDS];
    logic [31:0]      rd0_r;
    logic [31:0]      rd1_r;
    logic [7:0]       fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [7:0]       count_r;
    logic             overflow_r;
    logic             con_valid_r;
    logic [7:0]       con_data_r;
    logic [31:0]      timer_r;

    // ---------------------------------------------------------------
    // Combinational next-state
    // ---------------------------------------------------------------
    logic [ADDR_BITS-1:0] wr_idx_s;
    logic [ADDR_BITS-1:0] rd0_idx_s;
    logic [ADDR_BITS-1:0] rd1_idx_s;
    logic                 ram_we_s;
    logic [31:0]          rd0_ram_s;
    logic [31:0]          rd1_ram_s;
    logic [31:0]          rd0_next_s;
    logic [31:0]          rd1_next_s;
    logic [31:0]          status_s;

    logic                 push_req_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 push_ok_s;
    logic                 drop_s;
    logic [PTR_W-1:0]     wr_ptr_next_s;
    logic [PTR_W-1:0]     rd_ptr_next_s;
    logic [7:0]           count_next_s;
    logic [7:0]           head_next_s;
    logic                 timer_load_s;

    assign wr_idx_s  = bus.mem_write_addr[ADDR_BITS+1:2];
    assign rd0_idx_s = bus.mem_read0_addr[ADDR_BITS+1:2];
    assign rd1_idx_s = bus.mem_read1_addr[ADDR_BITS+1:2];
    assign status_s  = {overflow_r, 23'b0, count_r};

    // Read muxes: same-word collisions see the written lanes merged over the old word
    always_comb begin
        ram_we_s   = (bus.mem_we != 4'b0000) && !is_mmio(bus.mem_write_addr);
        rd0_ram_s  = ram_r[rd0_idx_s];
        rd1_ram_s  = ram_r[rd1_idx_s];
        rd0_next_s = rd0_ram_s;
        rd1_next_s = rd1_ram_s;

        if (ram_we_s && (rd0_idx_s == wr_idx_s)) begin
            rd0_ram_s = merge_lanes(ram_r[rd0_idx_s], bus.mem_write_data, bus.mem_we);
        end else begin
            rd0_ram_s = ram_r[rd0_idx_s];
        end
        if (ram_we_s && (rd1_idx_s == wr_idx_s)) begin
            rd1_ram_s = merge_lanes(ram_r[rd1_idx_s], bus.mem_write_data, bus.mem_we);
        end else begin
            rd1_ram_s = ram_r[rd1_idx_s];
        end

        if (bus.mem_read0_addr == CONSOLE_ADDR) begin
            rd0_next_s = status_s;
        end else if (bus.mem_read0_addr == TIMER_ADDR) begin
            rd0_next_s = timer_r;
        end else begin
            rd0_next_s = rd0_ram_s;
        end
        if (bus.mem_read1_addr == CONSOLE_ADDR) begin
            rd1_next_s = status_s;
        end else if (bus.mem_read1_addr == TIMER_ADDR) begin
            rd1_next_s = timer_r;
        end else begin
            rd1_next_s = rd1_ram_s;
        end
    end

    // Console FIFO control: a pop frees a slot for a same-cycle push even when full
    always_comb begin
        push_req_s    = bus.mem_we[0] && (bus.mem_write_addr == CONSOLE_ADDR);
        pop_s         = con_valid_r && bus.con_ready;
        full_s        = (count_r == DEPTH_CNT);
        push_ok_s     = push_req_s && (!full_s || pop_s);
        drop_s        = push_req_s && full_s && !pop_s;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;

        case ({push_ok_s, pop_s})
            2'b10: begin
                wr_ptr_next_s = ptr_inc(wr_ptr_r);
                count_next_s  = count_r + 8'd1;
            end
            2'b01: begin
                rd_ptr_next_s = ptr_inc(rd_ptr_r);
                count_next_s  = count_r - 8'd1;
            end
            2'b11: begin
                wr_ptr_next_s = ptr_inc(wr_ptr_r);
                rd_ptr_next_s = ptr_inc(rd_ptr_r);
            end
            default: begin
                count_next_s = count_r;
            end
        endcase

        // The byte being pushed this edge lands exactly at the new head when the
        // FIFO was empty, or held one entry that is being popped.
        if (count_next_s == 8'd0) begin
            head_next_s = 8'h00;
        end else if (push_ok_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = bus.mem_write_data[7:0];
        end else begin
            head_next_s = fifo_r[rd_ptr_next_s];
        end

        timer_load_s = (bus.mem_we == 4'b1111) && (bus.mem_write_addr == TIMER_ADDR);
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_we[i]) begin
                    ram_r[wr_idx_s][8*i +: 8] <= bus.mem_write_data[8*i +: 8];
                end
            end
        end
    end

    // Registered read data for both ports
    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_r <= 32'h0000_0000;
            rd1_r <= 32'h0000_0000;
        end else begin
            rd0_r <= rd0_next_s;
            rd1_r <= rd1_next_s;
        end
    end

    // FIFO storage; a push coinciding with reset is discarded
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            fifo_r[wr_ptr_r] <= bus.mem_write_data[7:0];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and registered drain outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= 8'd0;
            overflow_r  <= 1'b0;
            con_valid_r <= 1'b0;
            con_data_r  <= 8'h00;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            overflow_r  <= overflow_r | drop_s;
            con_valid_r <= (count_next_s != 8'd0);
            con_data_r  <= head_next_s;
        end
    end

    // Cycle timer: a full-word write loads instead of incrementing
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= 32'h0000_0000;
        end else if (timer_load_s) begin
            timer_r <= bus.mem_write_data;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    assign bus.mem_read0_data = rd0_r;
    assign bus.mem_read1_data = rd1_r;
    assign bus.con_valid      = con_valid_r;
    assign bus.con_data       = con_data_r;

endmodule

// File: tb/tb_cpu_memory_system.sv
// Directed plus randomized checks of cpu_memory_system against a queue/array reference model.
module tb_cpu_memory_system;
    localparam int          AB  = 14;
    localparam logic [31:0] CON = 32'hFFFF_FFF0;
    localparam logic [31:0] TIM = 32'hFFFF_FFF4;
    localparam int          DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    cpu_memory_system_if bus();

    cpu_memory_system #(
        .ADDR_BITS(AB), .CONSOLE_ADDR(CON), .TIMER_ADDR(TIM), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [31:0] mem_m [int];
    logic [7:0]  q_m [$];
    logic        ovf_m = 1'b0;
    logic [31:0] tim_m = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic bit is_ram(input logic [31:0] a);
        return (a != CON) && (a != TIM);
    endfunction

    // Expected read value from model state before the edge; known=0 for never-written words
    task automatic exp_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        int idx;
        int widx;
        known = 1'b1;
        v = 32'h0;
        if (a == CON) begin
            v = {ovf_m, 23'b0, 8'(q_m.size())};
        end else if (a == TIM) begin
            v = tim_m;
        end else begin
            idx  = int'(a[AB+1:2]);
            widx = int'(bus.mem_write_addr[AB+1:2]);
            if (mem_m.exists(idx)) begin
                v = mem_m[idx];
                if (is_ram(bus.mem_write_addr) && bus.mem_we != 4'b0000 && widx == idx)
                    v = merge(v, bus.mem_write_data, bus.mem_we);
            end else begin
                known = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [31:0] e0, e1;
        bit k0, k1, pop;
        int widx;
        @(posedge clk);
        exp_read(bus.mem_read0_addr, e0, k0);
        exp_read(bus.mem_read1_addr, e1, k1);
        if (rst) begin
            e0 = 32'h0; e1 = 32'h0; k0 = 1'b1; k1 = 1'b1;
        end
        widx = int'(bus.mem_write_addr[AB+1:2]);
        if (is_ram(bus.mem_write_addr) && bus.mem_we != 4'b0000) begin
            if (mem_m.exists(widx))
                mem_m[widx] = merge(mem_m[widx], bus.mem_write_data, bus.mem_we);
            else if (bus.mem_we == 4'b1111)
                mem_m[widx] = bus.mem_write_data;
        end
        if (rst) begin
            q_m.delete();
            ovf_m = 1'b0;
            tim_m = 32'h0;
        end else begin
            pop = (q_m.size() != 0) && bus.con_ready;
            if (pop) void'(q_m.pop_front());
            if (bus.mem_we[0] && bus.mem_write_addr == CON) begin
                if (q_m.size() < DEPTH) q_m.push_back(bus.mem_write_data[7:0]);
                else ovf_m = 1'b1;
            end
            if (bus.mem_we == 4'b1111 && bus.mem_write_addr == TIM) tim_m = bus.mem_write_data;
            else tim_m = tim_m + 32'd1;
        end
        #1;
        if (k0) chk("rd0", bus.mem_read0_data, e0);
        if (k1) chk("rd1", bus.mem_read1_data, e1);
        chk("con_valid", {31'b0, bus.con_valid}, {31'b0, (q_m.size() != 0)});
        chk("con_data", {24'b0, bus.con_data}, {24'b0, (q_m.size() != 0) ? q_m[0] : 8'h00});
    endtask

    task automatic drive(input logic [31:0] a0, input logic [31:0] a1, input logic [3:0] we,
                         input logic [31:0] wa, input logic [31:0] wd);
        bus.mem_read0_addr = a0;
        bus.mem_read1_addr = a1;
        bus.mem_we         = we;
        bus.mem_write_addr = wa;
        bus.mem_write_data = wd;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] r;
        int sel;
        sel = $urandom_range(7);
        r = $urandom();
        if (sel == 0) return CON;
        if (sel == 1) return TIM;
        return {r[31:16], 9'b0, r[6:2], r[1:0]};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  last;
        logic [31:0] rv;
        drive(CON, CON, 4'b0000, 32'h0, 32'h0);
        bus.con_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        chk("reset_rd0", bus.mem_read0_data, 32'h0);
        chk("reset_rd1", bus.mem_read1_data, 32'h0);
        chk("reset_valid", {31'b0, bus.con_valid}, 32'h0);
        chk("reset_data", {24'b0, bus.con_data}, 32'h0);
        rst = 1'b0;

        // Clear the words used below
        for (int i = 0; i < 32; i++) begin
            drive(CON, CON, 4'b1111, 32'(i * 4), 32'h0);
            step();
        end
        drive(CON, CON, 4'b1111, 32'h200, 32'h0);
        step();

        // Byte lanes
        drive(CON, CON, 4'b1111, 32'h100, 32'hAABBCCDD);
        step();
        drive(CON, CON, 4'b0101, 32'h100, 32'h11223344);
        step();
        drive(CON, 32'h100, 4'b0000, 32'h0, 32'h0);
        step();
        chk("byte_lanes", bus.mem_read1_data, 32'hAA22CC44);

        // Read-during-write collision on both ports
        drive(32'h200, 32'h200, 4'b1100, 32'h200, 32'h12345678);
        step();
        chk("collide_rd0", bus.mem_read0_data, 32'h12340000);
        chk("collide_rd1", bus.mem_read1_data, 32'h12340000);

        // Latency and address aliasing
        drive(CON, CON, 4'b1111, 32'h4, 32'hCAFE0001);
        step();
        drive(CON, CON, 4'b1111, 32'h8, 32'h0BADF00D);
        step();
        drive(32'h8, CON, 4'b0000, 32'h0, 32'h0);
        step();
        chk("lat_a", bus.mem_read0_data, 32'h0BADF00D);
        bus.mem_read0_addr = 32'h4;
        step();
        chk("lat_b", bus.mem_read0_data, 32'hCAFE0001);
        bus.mem_read0_addr = 32'h4 + (32'd4 << AB);
        step();
        chk("alias", bus.mem_read0_data, 32'hCAFE0001);
        bus.mem_read0_addr = 32'h8;
        step();
        chk("lat_c", bus.mem_read0_data, 32'h0BADF00D);

        // Full FIFO with simultaneous push and pop
        bus.con_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(CON, CON, 4'b0001, CON, 32'(8'h61 + i));
            step();
        end
        bus.con_ready = 1'b1;
        drive(CON, CON, 4'b0001, CON, 32'h5A);
        step();
        drive(CON, CON, 4'b0000, 32'h0, 32'h0);
        last = 8'h00;
        if (bus.con_valid) last = bus.con_data;
        step();
        chk("full_pushpop_status", bus.mem_read0_data, 32'h00000008);
        for (int i = 0; i < 12; i++) begin
            if (bus.con_valid) last = bus.con_data;
            step();
        end
        chk("pushpop_last", {24'b0, last}, 32'h5A);
        chk("pushpop_empty", {31'b0, bus.con_valid}, 32'h0);

        // Overflow: nine pushes into an eight-entry FIFO
        bus.con_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(CON, CON, 4'b0001, CON, 32'(8'h41 + i));
            step();
        end
        drive(CON, CON, 4'b0000, 32'h0, 32'h0);
        step();
        chk("overflow_status", bus.mem_read1_data, 32'h80000008);
        bus.con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'b0, bus.con_valid}, 32'h1);
            chk("drain_data", {24'b0, bus.con_data}, 32'(8'h41 + i));
            step();
        end
        chk("drain_empty", {31'b0, bus.con_valid}, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rv = $urandom();
            drive(rnd_addr(), rnd_addr(), (rv[0] ? rv[7:4] : 4'b0000), rnd_addr(), $urandom());
            bus.con_ready = rv[8];
            rst = (rv[15:10] == 6'd0);
            step();
        end
        rst = 1'b0;

        // Timer load and wrap
        drive(CON, CON, 4'b1111, TIM, 32'hFFFFFFFE);
        step();
        drive(TIM, CON, 4'b0000, 32'h0, 32'h0);
        step();
        chk("timer_load", bus.mem_read0_data, 32'hFFFFFFFE);
        step();
        step();
        chk("timer_wrap", bus.mem_read0_data, 32'h00000000);

        // Reset mid-operation keeps RAM
        drive(TIM, CON, 4'b0001, CON, 32'h77);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rd0", bus.mem_read0_data, 32'h0);
        chk("rst_rd1", bus.mem_read1_data, 32'h0);
        chk("rst_valid", {31'b0, bus.con_valid}, 32'h0);
        chk("rst_data", {24'b0, bus.con_data}, 32'h0);
        drive(CON, 32'h100, 4'b0000, 32'h0, 32'h0);
        step();
        chk("ram_kept", bus.mem_read1_data, 32'hAA22CC44);
        chk("rst_status", bus.mem_read0_data, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
